// File: rtl/blink_round_ctrl.sv
// Round sequencer for the Blink reaction game.
// Each round lights one pseudo-random LED, runs a countdown window and turns the
// registered coincidence flag from the validity checker into a hit or a miss.
// Score and lives are tracked per game, and the window shrinks after every hit.
module blink_round_ctrl #(
  parameter int unsigned WINDOW_INIT = 50_000_000,
  parameter int unsigned WINDOW_MIN  = 5_000_000,
  parameter int unsigned WINDOW_STEP = 2_500_000,
  parameter int unsigned LIVES       = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] switches,
  input  logic        hit,
  output logic [15:0] led,
  output logic [7:0]  score,
  output logic [2:0]  lives_left,
  output logic        playing,
  output logic        game_over
);

  localparam int unsigned LED_W = 16;
  localparam int unsigned CNT_W = 32;

  localparam logic [CNT_W-1:0] WIN_INIT   = CNT_W'(WINDOW_INIT);
  localparam logic [CNT_W-1:0] WIN_MIN    = CNT_W'(WINDOW_MIN);
  localparam logic [CNT_W-1:0] WIN_STEP   = CNT_W'(WINDOW_STEP);
  // Windows below this value would drop under the floor after one more step.
  localparam logic [CNT_W-1:0] WIN_THRESH = CNT_W'(WINDOW_MIN) + CNT_W'(WINDOW_STEP);
  localparam logic [2:0]       LIVES_INIT = 3'(LIVES);
  localparam logic [LED_W-1:0] LED_ALL    = {LED_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SHOW,
    S_JUDGE,
    S_OVER
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] window;
  logic [CNT_W-1:0] counter;
  logic [15:0]      lfsr;
  logic             lfsr_fb;
  logic [3:0]       prev_idx;
  logic [3:0]       pick_idx;
  logic             arm_held;
  logic             judge_hit;
  logic             wrong_switch;

  assign lfsr_fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign wrong_switch = (switches & ~led) != '0;

  // Free-running Fibonacci LFSR (taps 16,14,13,11), advances every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  // Next target index: never repeat the previous LED, bump by one (15 wraps to 0).
  always_comb begin
    pick_idx = lfsr[3:0];
    if (lfsr[3:0] == prev_idx) begin
      pick_idx = lfsr[3:0] + 4'd1;
    end
  end

  // Game state machine with registered outputs, score, lives and window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      led        <= '0;
      score      <= '0;
      lives_left <= LIVES_INIT;
      playing    <= 1'b0;
      game_over  <= 1'b0;
      window     <= WIN_INIT;
      counter    <= '0;
      prev_idx   <= '0;
      arm_held   <= 1'b0;
      judge_hit  <= 1'b0;
    end else begin
      case (state)
        // Waiting for a game: a start level launches a fresh one.
        S_IDLE, S_OVER: begin
          if (start) begin
            state      <= S_ARM;
            led        <= '0;
            score      <= '0;
            lives_left <= LIVES_INIT;
            window     <= WIN_INIT;
            playing    <= 1'b1;
            game_over  <= 1'b0;
            arm_held   <= 1'b0;
          end
        end

        // Dark gap: at least two cycles so the checker's flag flushes, then
        // wait for all switches released before lighting the next target.
        S_ARM: begin
          if (!arm_held) begin
            arm_held <= 1'b1;
          end else if (switches == '0) begin
            led      <= LED_W'(1) << pick_idx;
            prev_idx <= pick_idx;
            counter  <= window - CNT_W'(1);
            state    <= S_SHOW;
          end
        end

        // Target lit: hit beats wrong switch beats timeout.
        S_SHOW: begin
          if (hit) begin
            judge_hit <= 1'b1;
            led       <= '0;
            state     <= S_JUDGE;
          end else if (wrong_switch || (counter == '0)) begin
            judge_hit <= 1'b0;
            led       <= '0;
            state     <= S_JUDGE;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end

        // One-cycle bookkeeping of the round outcome.
        S_JUDGE: begin
          arm_held <= 1'b0;
          if (judge_hit) begin
            if (score != 8'hFF) begin
              score <= score + 8'd1;
            end
            if (window >= WIN_THRESH) begin
              window <= window - WIN_STEP;
            end else begin
              window <= WIN_MIN;
            end
            state <= S_ARM;
          end else begin
            lives_left <= lives_left - 3'd1;
            if (lives_left == 3'd1) begin
              state     <= S_OVER;
              playing   <= 1'b0;
              game_over <= 1'b1;
              led       <= LED_ALL;
            end else begin
              state <= S_ARM;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_round_ctrl.sv
// Scoreboard bench for blink_round_ctrl: a round-level game model pushes the
// expected outcome of every round; a monitor pops it when the DUT judges.
module tb_blink_round_ctrl;

  localparam int unsigned W_INIT  = 20;
  localparam int unsigned W_MIN   = 8;
  localparam int unsigned W_STEP  = 5;
  localparam int unsigned N_LIVES = 3;
  localparam logic [15:0] SEED    = 16'hACE1;

  localparam int ACT_HIT     = 0;
  localparam int ACT_TIMEOUT = 1;
  localparam int ACT_WRONG   = 2;
  localparam int ACT_BOTH    = 3;

  typedef struct {
    int show_len;
    int score;
    int lives;
    bit over;
  } round_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start;
  logic [15:0] switches;
  logic        hit;
  logic [15:0] led;
  logic [7:0]  score;
  logic [2:0]  lives_left;
  logic        playing;
  logic        game_over;

  round_t      rec_q[$];
  int          gap_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_lfsr;
  int          g_score, g_lives, g_window;

  blink_round_ctrl #(
    .WINDOW_INIT(W_INIT),
    .WINDOW_MIN (W_MIN),
    .WINDOW_STEP(W_STEP),
    .LIVES      (N_LIVES),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .switches  (switches),
    .hit       (hit),
    .led       (led),
    .score     (score),
    .lives_left(lives_left),
    .playing   (playing),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic bit is_onehot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic give_up(input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired waiting for the DUT", what);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Returns at the negedge of the first SHOW cycle.
  task automatic wait_show(output logic [15:0] tgt);
    int n;
    n = 0;
    @(negedge clk);
    while (!is_onehot(led)) begin
      n++;
      if (n > 600) give_up("wait_show");
      @(negedge clk);
    end
    tgt = led;
  endtask

  task automatic new_game();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g_score  = 0;
    g_lives  = N_LIVES;
    g_window = W_INIT;
  endtask

  // One round: act picks the player behaviour; tail >= 0 holds switches that
  // many cycles after the judgement, tail < 0 holds them until the model LFSR
  // nibble equals steer so the next target is chosen deliberately.
  task automatic play_round(input int act, input int tail, input logic [3:0] steer, input bit noise);
    logic [15:0] tgt, wrong;
    int          show_len, n;
    bit          is_hit;
    round_t      r;
    wait_show(tgt);
    wrong = 16'd1 << $urandom_range(0, 15);
    if (wrong == tgt) wrong = {wrong[14:0], wrong[15]};
    is_hit   = (act == ACT_HIT) || (act == ACT_BOTH);
    show_len = (act == ACT_TIMEOUT) ? g_window : ((act == ACT_WRONG) ? 2 : 3);
    if (is_hit) begin
      if (g_score < 255) g_score++;
      g_window = (g_window >= int'(W_MIN + W_STEP)) ? g_window - int'(W_STEP) : int'(W_MIN);
    end else begin
      g_lives--;
    end
    r.show_len = show_len;
    r.score    = g_score;
    r.lives    = g_lives;
    r.over     = (g_lives == 0);
    rec_q.push_back(r);
    if (!r.over) gap_q.push_back((tail < 0) ? 0 : ((tail + 1 > 3) ? tail + 1 : 3));
    if (noise) start = 1'b1;
    case (act)
      ACT_HIT: begin
        @(negedge clk); switches = tgt;
        @(negedge clk); hit = 1'b1;
        @(negedge clk);
      end
      ACT_BOTH: begin
        @(negedge clk); switches = tgt;
        @(negedge clk); switches = tgt | wrong; hit = 1'b1;
        @(negedge clk);
      end
      ACT_WRONG: begin
        @(negedge clk); switches = wrong;
        @(negedge clk);
      end
      default: repeat (show_len) @(negedge clk);
    endcase
    // Now in the judgement cycle.
    start = 1'b0;
    if (tail < 0) begin
      switches = 16'h0101;
      @(negedge clk);
      hit = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n > 500) give_up("steer");
      end while (m_lfsr[3:0] != steer);
      switches = 16'h0000;
    end else begin
      switches = (tail > 0) ? 16'h0101 : 16'h0000;
      repeat (tail) begin
        @(negedge clk);
        hit = 1'b0;
      end
      switches = 16'h0000;
      hit = 1'b0;
    end
  endtask

  // Reset asserted in the middle of a lit round.
  task automatic abort_round();
    logic [15:0] tgt;
    wait_show(tgt);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    switches = 16'h0000;
    hit = 1'b0;
  endtask

  // Outputs must clear as soon as reset rises, without a clock edge.
  initial begin : reset_monitor
    forever begin
      @(posedge rst);
      #1;
      check("rst_led", 32'(led), 32'd0);
      check("rst_score", 32'(score), 32'd0);
      check("rst_lives", 32'(lives_left), 32'(N_LIVES));
      check("rst_playing", 32'(playing), 32'd0);
      check("rst_game_over", 32'(game_over), 32'd0);
    end
  end

  // Round monitor: target choice from an LFSR model, round outcome from the scoreboard.
  initial begin : round_monitor
    logic [15:0] used, exp_led;
    logic [3:0]  exp_idx, m_prev;
    bit          in_show, judge_seen, have_gap, prev_playing;
    int          show_cnt, gap_cnt, exp_gap;
    round_t      r;
    m_lfsr = SEED; m_prev = 4'd0; in_show = 0; judge_seen = 0; have_gap = 0;
    prev_playing = 0; show_cnt = 0; gap_cnt = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_lfsr = SEED; m_prev = 4'd0; in_show = 0; judge_seen = 0; have_gap = 0; prev_playing = 0;
        continue;
      end
      used   = m_lfsr;
      m_lfsr = lfsr_step(m_lfsr);
      #1;
      if (playing && !prev_playing) begin
        check("start_score", 32'(score), 32'd0);
        check("start_lives", 32'(lives_left), 32'(N_LIVES));
        check("start_game_over", 32'(game_over), 32'd0);
        check("start_led", 32'(led), 32'd0);
      end
      prev_playing = playing;
      if (judge_seen) begin
        judge_seen = 0;
        n_tests++;
        if (rec_q.size() == 0) begin
          n_fail++;
          $display("FAIL round_end: got an unexpected judgement, expected none");
        end else begin
          n_tests--;
          r = rec_q.pop_front();
          check("show_len", 32'(show_cnt), 32'(r.show_len));
          check("score", 32'(score), 32'(r.score));
          check("lives_left", 32'(lives_left), 32'(r.lives));
          check("game_over", 32'(game_over), 32'(r.over));
          check("playing", 32'(playing), 32'(!r.over));
          check("led_after_judge", 32'(led), r.over ? 32'h0000_FFFF : 32'd0);
          if (!r.over) begin
            have_gap = 1;
            gap_cnt  = 1;
          end
        end
      end
      if (in_show) begin
        if (is_onehot(led)) begin
          show_cnt++;
        end else begin
          in_show    = 0;
          judge_seen = 1;
          check("judge_led", 32'(led), 32'd0);
        end
      end else if (is_onehot(led)) begin
        exp_idx = (used[3:0] == m_prev) ? used[3:0] + 4'd1 : used[3:0];
        exp_led = 16'd1 << exp_idx;
        check("show_led", 32'(led), 32'(exp_led));
        m_prev   = exp_idx;
        in_show  = 1;
        show_cnt = 1;
        if (have_gap) begin
          have_gap = 0;
          exp_gap  = (gap_q.size() != 0) ? gap_q.pop_front() : -1;
          if (exp_gap != 0) check("arm_gap", 32'(gap_cnt), 32'(exp_gap));
        end
      end else if (have_gap) begin
        gap_cnt++;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    give_up("watchdog");
  end

  // Stimulus: directed game, random game, saturation game with abort, fresh game.
  initial begin : stimulus
    start = 1'b0;
    switches = 16'h0000;
    hit = 1'b0;
    g_score = 0; g_lives = N_LIVES; g_window = W_INIT;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Game 1: directed hits, timeouts, wrong switch, simultaneous hit/wrong, steered targets.
    new_game();
    play_round(ACT_HIT,     4,  4'd0,  1'b0);
    play_round(ACT_TIMEOUT, 0,  4'd0,  1'b0);
    play_round(ACT_HIT,     1,  4'd0,  1'b0);
    play_round(ACT_HIT,     0,  4'd0,  1'b0);
    play_round(ACT_BOTH,    -1, 4'd15, 1'b0);
    play_round(ACT_HIT,     -1, 4'd15, 1'b0);
    play_round(ACT_HIT,     1,  4'd0,  1'b0);
    play_round(ACT_TIMEOUT, 2,  4'd0,  1'b0);
    play_round(ACT_WRONG,   0,  4'd0,  1'b0);

    // Game 2: random rounds started from OVER, with stray start levels.
    new_game();
    for (int i = 0; i < 40 && g_lives > 0; i++) begin
      play_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 4'd0,
                 1'($urandom_range(0, 1)));
    end
    while (g_lives > 0) play_round(ACT_TIMEOUT, 0, 4'd0, 1'b0);

    // Game 3: score saturation, then reset in the middle of a lit round.
    new_game();
    for (int i = 0; i < 258; i++) begin
      play_round(ACT_HIT, int'($urandom_range(0, 1)), 4'd0, 1'b0);
    end
    abort_round();

    // Game 4: fresh game from IDLE after the abort.
    new_game();
    play_round(ACT_HIT,     0, 4'd0, 1'b0);
    play_round(ACT_WRONG,   0, 4'd0, 1'b0);
    play_round(ACT_TIMEOUT, 3, 4'd0, 1'b0);
    play_round(ACT_BOTH,    0, 4'd0, 1'b0);
    while (g_lives > 0) play_round(ACT_WRONG, 0, 4'd0, 1'b0);

    repeat (5) @(negedge clk);
    check("records_left", 32'(rec_q.size()), 32'd0);
    check("gaps_left", 32'(gap_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
